// File: rtl/bcd_tick_counter_if.sv
// Signal bundle for the BCD tick counter: control inputs (en/up/load/din) and
// the digit, terminal-count and carry outputs.
interface bcd_tick_counter_if;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] din;
   logic       A;
   logic       B;
   logic       C;
   logic       D;
   logic       tc;
   logic       carry;

   // Driver side: supplies controls and observes the counter outputs
   modport master (
      output en, up, load, din,
      input  A, B, C, D, tc, carry
   );

   // Counter side: consumes controls and drives the digit/status outputs
   modport slave (
      input  en, up, load, din,
      output A, B, C, D, tc, carry
   );
endinterface

// File: rtl/bcd_tick_counter.sv
// Single-digit BCD up/down counter advanced once every DIV enabled clocks.
// The digit drives a 7-segment decoder through A (MSB) .. D (LSB). carry
// pulses for one cycle on each 9->0 or 0->9 wrap.
module bcd_tick_counter #(
   parameter int unsigned DIV = 12000000
) (
   input logic              clk,
   input logic              rst_n,
   bcd_tick_counter_if.slave bus
);

   localparam int unsigned PW = (DIV <= 1) ? 1 : $clog2(DIV);
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] pre;
   logic [3:0]    digit;
   logic          carry_q;
   logic [3:0]    stepped;
   logic          wraps;
   logic          step;
   logic [3:0]    load_value;

   assign step       = bus.en && (pre == LAST);
   assign load_value = (bus.din <= 4'd9) ? bus.din : 4'd0;

   // Value the digit takes on a step in the current direction, and whether it wraps
   always_comb begin
      stepped = digit;
      wraps   = 1'b0;
      if (bus.up) begin
         if (digit >= 4'd9) begin
            stepped = 4'd0;
            wraps   = 1'b1;
         end else begin
            stepped = digit + 4'd1;
         end
      end else begin
         if (digit == 4'd0) begin
            stepped = 4'd9;
            wraps   = 1'b1;
         end else begin
            stepped = digit - 4'd1;
         end
      end
   end

   // Prescaler, digit and carry; load wins over a coincident step regardless of en
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre     <= '0;
         digit   <= 4'd0;
         carry_q <= 1'b0;
      end else begin
         carry_q <= 1'b0;
         if (bus.load) begin
            digit <= load_value;
            pre   <= '0;
         end else if (bus.en) begin
            if (step) begin
               pre     <= '0;
               digit   <= stepped;
               carry_q <= wraps;
            end else begin
               pre <= pre + PW'(1);
            end
         end
      end
   end

   assign bus.A     = digit[3];
   assign bus.B     = digit[2];
   assign bus.C     = digit[1];
   assign bus.D     = digit[0];
   assign bus.carry = carry_q;
   assign bus.tc    = bus.up ? (digit == 4'd9) : (digit == 4'd0);

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Self-checking bench: a DIV=4 and a DIV=1 counter share stimulus and are both
// compared every cycle against a tick-counting arithmetic model.
module tb_bcd_tick_counter;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   int checks = 0;
   int failures = 0;

   int divs [2] = '{4, 1};
   int mDigit [2];
   int mCnt [2];
   int mCarry [2];
   logic curUp = 1'b1;

   bcd_tick_counter_if bus4 ();
   bcd_tick_counter_if bus1 ();

   bcd_tick_counter #(.DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
   bcd_tick_counter #(.DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   // Free-running clock, period 10
   always #5 clk = ~clk;

   // Count one comparison and report it if observed differs from expected
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         failures++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int digit4();
      return int'({bus4.A, bus4.B, bus4.C, bus4.D});
   endfunction

   function automatic int digit1();
      return int'({bus1.A, bus1.B, bus1.C, bus1.D});
   endfunction

   // Reference behaviour for one clock edge of instance k
   task automatic modelEdge(input int k, input logic e, input logic u, input logic l, input int d);
      mCarry[k] = 0;
      if (l) begin
         mDigit[k] = (d <= 9) ? d : 0;
         mCnt[k] = 0;
      end else if (e) begin
         mCnt[k] = mCnt[k] + 1;
         if (mCnt[k] == divs[k]) begin
            mCnt[k] = 0;
            if (u) begin
               mDigit[k] = (mDigit[k] + 1) % 10;
               if (mDigit[k] == 0) mCarry[k] = 1;
            end else begin
               mDigit[k] = (mDigit[k] + 9) % 10;
               if (mDigit[k] == 9) mCarry[k] = 1;
            end
         end
      end
   endtask

   function automatic int expectTc(input int dig, input logic u);
      return u ? int'(dig == 9) : int'(dig == 0);
   endfunction

   task automatic compareAll(input string tag);
      checkOutput({tag, " digit4"}, digit4(), mDigit[0]);
      checkOutput({tag, " carry4"}, int'(bus4.carry), mCarry[0]);
      checkOutput({tag, " tc4"}, int'(bus4.tc), expectTc(mDigit[0], curUp));
      checkOutput({tag, " digit1"}, digit1(), mDigit[1]);
      checkOutput({tag, " carry1"}, int'(bus1.carry), mCarry[1]);
      checkOutput({tag, " tc1"}, int'(bus1.tc), expectTc(mDigit[1], curUp));
   endtask

   // One clock: drive inputs, let the edge happen, advance model, compare
   task automatic applyStimulus(input logic e, input logic u, input logic l, input logic [3:0] d, input string tag);
      bus4.en = e; bus4.up = u; bus4.load = l; bus4.din = d;
      bus1.en = e; bus1.up = u; bus1.load = l; bus1.din = d;
      curUp = u;
      @(posedge clk);
      for (int k = 0; k < 2; k++) modelEdge(k, e, u, l, int'(d));
      #1;
      compareAll(tag);
   endtask

   // Asynchronous reset pulse in the middle of a cycle, optionally with load held high
   task automatic doReset(input logic withLoad);
      bus4.en = 1'b0; bus1.en = 1'b0;
      bus4.load = withLoad; bus1.load = withLoad;
      bus4.din = 4'd5; bus1.din = 4'd5;
      #3;
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         mDigit[k] = 0;
         mCnt[k] = 0;
         mCarry[k] = 0;
      end
      #1;
      compareAll("reset_async");
      @(posedge clk);
      #1;
      compareAll("reset_held");
      bus4.load = 1'b0; bus1.load = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      bus4.en = 1'b0; bus4.up = 1'b1; bus4.load = 1'b0; bus4.din = 4'd0;
      bus1.en = 1'b0; bus1.up = 1'b1; bus1.load = 1'b0; bus1.din = 4'd0;

      // Count up for 40 clocks: full decade on DIV=4, wrap carry on clock 40
      doReset(1'b0);
      for (int i = 1; i <= 40; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, "count_up");
         if (i == 10) begin
            checkOutput("div1_digit_at_10", digit1(), 0);
            checkOutput("div1_carry_at_10", int'(bus1.carry), 1);
         end
         if (i == 36) checkOutput("digit9_at_36", digit4(), 9);
      end
      checkOutput("digit_at_40", digit4(), 0);
      checkOutput("carry_at_40", int'(bus4.carry), 1);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, "carry_drop");
      checkOutput("carry_after_40", int'(bus4.carry), 0);

      // Count down from reset: tc while at 0, borrow to 9 on clock 4, then 8
      doReset(1'b0);
      curUp = 1'b0; bus4.up = 1'b0; bus1.up = 1'b0;
      #1;
      checkOutput("tc_down_at_zero", int'(bus4.tc), 1);
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, "count_down");
         if (i == 4) begin
            checkOutput("down_digit_at_4", digit4(), 9);
            checkOutput("down_borrow_at_4", int'(bus4.carry), 1);
         end
      end
      checkOutput("down_digit_at_8", digit4(), 8);

      // Load coincident with a step wins, restarts prescaler; out-of-range din gives 0
      doReset(1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, "pre_load");
      applyStimulus(1'b1, 1'b1, 1'b1, 4'd7, "load_step");
      checkOutput("load_digit", digit4(), 7);
      checkOutput("load_no_carry", int'(bus4.carry), 0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, "post_load");
      checkOutput("post_load_hold", digit4(), 7);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, "post_load_step");
      checkOutput("post_load_step", digit4(), 8);
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd12, "load_bad");
      checkOutput("load_bad_digit", digit4(), 0);

      // Enable gap freezes the prescaler with no lost or extra step
      doReset(1'b0);
      for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, "gap_pre");
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 4'd0, "gap_off");
      checkOutput("gap_frozen", digit4(), 0);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, "gap_resume");
      checkOutput("gap_no_early_step", digit4(), 0);
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, "gap_resume");
      checkOutput("gap_step", digit4(), 1);

      // Reset mid-count at digit 6 / prescaler 2, then reset during a load
      doReset(1'b0);
      for (int i = 0; i < 26; i++) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, "pre_reset");
      checkOutput("digit6_before_reset", digit4(), 6);
      doReset(1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 4'd0, "restart");
      checkOutput("restart_first_step", digit4(), 1);
      doReset(1'b1);

      // Randomized mix of enable, direction, load and occasional async reset
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) < 2) begin
            doReset(1'($urandom_range(0, 1)));
         end else begin
            if ($urandom_range(0, 9) == 0) curUp = ~curUp;
            applyStimulus(1'($urandom_range(0, 3) != 0), curUp,
                          1'($urandom_range(0, 99) < 5), 4'($urandom_range(0, 15)), "random");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   // Hard time limit so the run always terminates
   initial begin
      #500000;
      $display("[TB] FAIL timeout: observed running, expected finished");
      $fatal(1, "[TB] time limit reached");
   end

endmodule
